// File: rtl/wiscsc15_mc_ctrl.sv
// ---------------------------------------------------------------------------
// wiscsc15_mc_ctrl
// Multi-cycle sequencing control for the WISC-SC15 datapath. Each instruction
// walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The opcode is latched once
// per instruction. Memory waits are bounded by MEM_TMO, and retired
// instructions are counted.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   run                 allow a new fetch (sampled in FETCH only)
//   opcode              IR opcode field, valid while im_ready is high
//   im_ready, dm_ready  instruction / data memory handshakes
//   br_taken            branch condition, sampled in EXEC
//   opcode_q            latched opcode of the instruction in flight
//   im_read, ir_we      fetch request, IR load strobe
//   dm_read, dm_write   data memory requests
//   rf_w, pc_we, pc_src register file write, PC write, PC source select
//   aluop               ALU operation code
//   instr_cnt           retired-instruction counter (wraps)
//   halted, err         stopped flag, memory-timeout flag
// ---------------------------------------------------------------------------
module wiscsc15_mc_ctrl #(
  parameter int unsigned OPW     = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned MEM_TMO = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [OPW-1:0]   opcode,
  input  logic             im_ready,
  input  logic             dm_ready,
  input  logic             br_taken,
  output logic [OPW-1:0]   opcode_q,
  output logic             im_read,
  output logic             ir_we,
  output logic             dm_read,
  output logic             dm_write,
  output logic             rf_w,
  output logic             pc_we,
  output logic             pc_src,
  output logic [OPW-2:0]   aluop,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             halted,
  output logic             err
);

  localparam int unsigned ALUOPW = OPW - 1;
  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] TMO = WAIT_W'(MEM_TMO);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;

  // Opcode class decode of the latched instruction
  logic is_alu, is_lw, is_sw, is_br, is_call, is_ret, is_halt, is_mem;

  always_comb begin
    is_alu  = ~opcode_q[3];
    is_lw   = (opcode_q[3:0] == 4'b1000);
    is_sw   = (opcode_q[3:0] == 4'b1001);
    is_br   = (opcode_q[3:0] == 4'b1100);
    is_call = (opcode_q[3:0] == 4'b1101);
    is_ret  = (opcode_q[3:0] == 4'b1110);
    is_halt = (opcode_q[3:0] == 4'b1111);
    is_mem  = is_lw | is_sw | is_call | is_ret;
  end

  // Sequencer: state, opcode latch, wait counter, retire counter, status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      opcode_q  <= '0;
      instr_cnt <= '0;
      halted    <= 1'b0;
      err       <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_FETCH;
          wait_cnt <= '0;
        end

        S_FETCH: begin
          if (!run) begin
            // Stalled by run: no fetch pending, so nothing to time out
            wait_cnt <= '0;
          end else if (im_ready) begin
            opcode_q <= opcode;
            state    <= S_DECODE;
          end else if (wait_cnt == TMO) begin
            state  <= S_HALT;
            halted <= 1'b1;
            err    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        S_DECODE: begin
          if (is_halt) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state <= S_EXEC;
          end
        end

        S_EXEC: begin
          if (is_mem) begin
            state    <= S_MEM;
            wait_cnt <= '0;
          end else if (is_br) begin
            // Branches resolve here and retire without a WB cycle
            state     <= S_FETCH;
            wait_cnt  <= '0;
            instr_cnt <= instr_cnt + CNT_W'(1);
          end else begin
            state <= S_WB;
          end
        end

        S_MEM: begin
          // A ready arriving on the timeout count wins over the error
          if (dm_ready) begin
            if (is_sw) begin
              state     <= S_FETCH;
              wait_cnt  <= '0;
              instr_cnt <= instr_cnt + CNT_W'(1);
            end else begin
              state <= S_WB;
            end
          end else if (wait_cnt == TMO) begin
            state  <= S_HALT;
            halted <= 1'b1;
            err    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        S_WB: begin
          state     <= S_FETCH;
          wait_cnt  <= '0;
          instr_cnt <= instr_cnt + CNT_W'(1);
        end

        S_HALT: begin
          state <= S_HALT;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobe decode from state and latched opcode; ir_we/im_read follow the
  // fetch handshake and the SW PC update follows dm_ready
  always_comb begin
    im_read  = 1'b0;
    ir_we    = 1'b0;
    dm_read  = 1'b0;
    dm_write = 1'b0;
    rf_w     = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 1'b0;
    aluop    = '0;
    case (state)
      S_FETCH: begin
        im_read = run;
        ir_we   = run & im_ready;
      end

      S_EXEC: begin
        if (is_alu) begin
          aluop = opcode_q[ALUOPW-1:0];
        end else if (is_call) begin
          aluop = ALUOPW'(1);
        end
        if (is_br) begin
          pc_we  = 1'b1;
          pc_src = br_taken;
        end
      end

      S_MEM: begin
        dm_read  = is_lw | is_ret;
        dm_write = is_sw | is_call;
        // SW has no WB cycle, so its PC+1 update happens on completion
        if (is_sw && dm_ready) begin
          pc_we = 1'b1;
        end
      end

      S_WB: begin
        rf_w   = 1'b1;
        pc_we  = 1'b1;
        pc_src = is_call | is_ret;
      end

      default: begin
      end
    endcase
  end

endmodule
